// File: rtl/vector_line_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vector_line_sequencer
// Purpose  : Buffers vector-list line segments, launches them one at a time
//            into the line rasterizer and flips the draw buffer at vblank once
//            the last line of a frame is finished.
//            Optional feature macro: VECTOR_TRIVIAL_REJECT_EN
// Revision : 1.0 - initial release
// ============================================================================
module vector_line_sequencer #(
  parameter int DEPTH = 16,
  parameter int CW    = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_start_x,
  input  logic [CW-1:0] in_start_y,
  input  logic [CW-1:0] in_end_x,
  input  logic [CW-1:0] in_end_y,
  input  logic [3:0]    in_color,
  input  logic          in_last,
  input  logic          rast_ready,
  input  logic          rast_done,
  output logic          rast_go,
  output logic [CW-1:0] rast_start_x,
  output logic [CW-1:0] rast_start_y,
  output logic [CW-1:0] rast_end_x,
  output logic [CW-1:0] rast_end_y,
  output logic [3:0]    rast_color,
  input  logic          vblank,
  output logic          buf_sel,
  output logic          frame_done,
  output logic [15:0]   line_count,
  output logic          busy
`ifdef VECTOR_TRIVIAL_REJECT_EN
  ,
  output logic [15:0]   reject_count
`endif
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = PW + 1;

  typedef struct packed {
    logic signed [CW-1:0] sx;
    logic signed [CW-1:0] sy;
    logic signed [CW-1:0] ex;
    logic signed [CW-1:0] ey;
    logic [3:0]           color;
    logic                 last;
  } seg_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_FLIP = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  seg_t            hold_q, hold_d;
  logic [15:0]     line_count_q, line_count_d;
  logic            buf_sel_q, buf_sel_d;
  logic            frame_done_q, frame_done_d;

  seg_t            mem_q [DEPTH];
  seg_t            in_seg;
  seg_t            head;
  logic            push;
  logic            pop;

  assign in_seg = '{sx: in_start_x, sy: in_start_y, ex: in_end_x, ey: in_end_y,
                    color: in_color, last: in_last};
  assign head   = mem_q[rd_ptr_q];

  assign in_ready = (count_q != CNTW'(DEPTH));
  assign push     = in_valid & in_ready;

`ifdef VECTOR_TRIVIAL_REJECT_EN
  localparam logic signed [CW-1:0] X_HI = CW'(320);
  localparam logic signed [CW-1:0] X_LO = CW'(-320);
  localparam logic signed [CW-1:0] Y_HI = CW'(240);
  localparam logic signed [CW-1:0] Y_LO = CW'(-240);

  logic [15:0] reject_count_q, reject_count_d;
  logic        reject;

  // Both endpoints beyond the same screen edge: the line can never be visible.
  assign reject = ((head.sx >= X_HI) && (head.ex >= X_HI)) ||
                  ((head.sx <  X_LO) && (head.ex <  X_LO)) ||
                  ((head.sy >= Y_HI) && (head.ey >= Y_HI)) ||
                  ((head.sy <  Y_LO) && (head.ey <  Y_LO));

  assign reject_count = reject_count_q;
`endif

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    hold_d       = hold_q;
    line_count_d = line_count_q;
    buf_sel_d    = buf_sel_q;
    frame_done_d = 1'b0;
    rast_go      = 1'b0;
    pop          = 1'b0;
`ifdef VECTOR_TRIVIAL_REJECT_EN
    reject_count_d = reject_count_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop = 1'b1;
`ifdef VECTOR_TRIVIAL_REJECT_EN
          if (reject) begin
            if (reject_count_q != 16'hFFFF) reject_count_d = reject_count_q + 16'd1;
            state_d = head.last ? ST_FLIP : ST_IDLE;
          end else begin
            hold_d  = head;
            state_d = ST_LOAD;
          end
`else
          hold_d  = head;
          state_d = ST_LOAD;
`endif
        end
      end
      ST_LOAD: begin
        rast_go = rast_ready;
        if (rast_ready) begin
          if (line_count_q != 16'hFFFF) line_count_d = line_count_q + 16'd1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rast_done) state_d = hold_q.last ? ST_FLIP : ST_IDLE;
      end
      ST_FLIP: begin
        if (vblank) begin
          buf_sel_d    = ~buf_sel_q;
          frame_done_d = 1'b1;
          line_count_d = '0;
`ifdef VECTOR_TRIVIAL_REJECT_EN
          reject_count_d = '0;
`endif
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hold_q       <= '0;
      line_count_q <= '0;
      buf_sel_q    <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef VECTOR_TRIVIAL_REJECT_EN
      reject_count_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hold_q       <= hold_d;
      line_count_q <= line_count_d;
      buf_sel_q    <= buf_sel_d;
      frame_done_q <= frame_done_d;
`ifdef VECTOR_TRIVIAL_REJECT_EN
      reject_count_q <= reject_count_d;
`endif
    end
  end

  // Storage needs no reset; count_q alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_seg;
  end

  assign rast_start_x = hold_q.sx;
  assign rast_start_y = hold_q.sy;
  assign rast_end_x   = hold_q.ex;
  assign rast_end_y   = hold_q.ey;
  assign rast_color   = hold_q.color;
  assign buf_sel      = buf_sel_q;
  assign frame_done   = frame_done_q;
  assign line_count   = line_count_q;
  assign busy         = (state_q != ST_IDLE) || (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_vector_line_sequencer.sv
`default_nettype none
// Bench for vector_line_sequencer: queue-based reference model compared every
// cycle, a small rasterizer stub, directed scenarios and a random stream.
module tb_vector_line_sequencer;

  localparam int DEPTH = 16;
  localparam int CW    = 13;

  typedef struct packed {
    logic signed [CW-1:0] sx;
    logic signed [CW-1:0] sy;
    logic signed [CW-1:0] ex;
    logic signed [CW-1:0] ey;
    logic [3:0]           color;
    logic                 last;
  } seg_t;

  localparam int M_IDLE = 0, M_OFFER = 1, M_DRAW = 2, M_VB = 3;

  logic clk, rst;
  logic in_valid, in_ready, in_last;
  logic signed [CW-1:0] in_start_x, in_start_y, in_end_x, in_end_y;
  logic [3:0] in_color;
  logic rast_ready, rast_done, rast_go;
  logic signed [CW-1:0] rast_start_x, rast_start_y, rast_end_x, rast_end_y;
  logic [3:0] rast_color;
  logic vblank, buf_sel, frame_done, busy;
  logic [15:0] line_count;
`ifdef VECTOR_TRIVIAL_REJECT_EN
  logic [15:0] reject_count;
`endif

  vector_line_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_start_x(in_start_x), .in_start_y(in_start_y),
    .in_end_x(in_end_x), .in_end_y(in_end_y),
    .in_color(in_color), .in_last(in_last),
    .rast_ready(rast_ready), .rast_done(rast_done), .rast_go(rast_go),
    .rast_start_x(rast_start_x), .rast_start_y(rast_start_y),
    .rast_end_x(rast_end_x), .rast_end_y(rast_end_y),
    .rast_color(rast_color),
    .vblank(vblank), .buf_sel(buf_sel), .frame_done(frame_done),
    .line_count(line_count), .busy(busy)
`ifdef VECTOR_TRIVIAL_REJECT_EN
    , .reject_count(reject_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- environment knobs ----------------
  seg_t src_q[$];
  int   valid_pct = 100, ready_pct = 100, vb_pct = 0;
  bit   rr_en = 1, vb_block = 1, done_hold = 0;
  bit   rbusy = 0;
  int   rcnt = 0;
  int   acc_cnt = 0, go_cnt = 0, fd_cnt = 0;
  int   last_acc_cyc = 0, last_go_cyc = 0;
  seg_t go_seg;

  function automatic seg_t mk(input int sx, input int sy, input int ex, input int ey,
                              input int col, input bit last);
    seg_t s;
    s.sx = CW'(sx); s.sy = CW'(sy); s.ex = CW'(ex); s.ey = CW'(ey);
    s.color = 4'(col); s.last = last;
    return s;
  endfunction

  function automatic seg_t rnd_seg(input int range, input bit last);
    return mk(int'($urandom_range(0, 2*range)) - range, int'($urandom_range(0, 2*range)) - range,
              int'($urandom_range(0, 2*range)) - range, int'($urandom_range(0, 2*range)) - range,
              int'($urandom_range(0, 15)), last);
  endfunction

  // Source, rasterizer stub and vblank generator; inputs change 1 time unit after the edge.
  always @(posedge clk) begin
    cyc++;
    if (rast_done) rbusy = 0;
    if (!rst) begin
      if (in_valid && in_ready) begin
        acc_cnt++; last_acc_cyc = cyc;
        void'(src_q.pop_front());
      end
      if (rast_go) begin
        go_cnt++; last_go_cyc = cyc;
        go_seg = mk(rast_start_x, rast_start_y, rast_end_x, rast_end_y, rast_color, 1'b0);
        rbusy = 1; rcnt = $urandom_range(0, 4);
      end
      if (frame_done) fd_cnt++;
    end
    #1;
    in_valid = 1'b0;
    if (src_q.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
      in_valid   = 1'b1;
      in_start_x = src_q[0].sx; in_start_y = src_q[0].sy;
      in_end_x   = src_q[0].ex; in_end_y   = src_q[0].ey;
      in_color   = src_q[0].color; in_last = src_q[0].last;
    end
    rast_done = 1'b0;
    if (rbusy && !done_hold) begin
      if (rcnt == 0) rast_done = 1'b1;
      else rcnt--;
    end
    rast_ready = !rbusy && rr_en && ($urandom_range(0, 99) < ready_pct);
    vblank     = !vb_block && ($urandom_range(0, 99) < vb_pct);
  end

  // ---------------- reference model ----------------
  seg_t        m_q[$];
  seg_t        m_cur, m_in, m_h;
  int          m_stage = M_IDLE;
  logic        m_buf = 1'b0, m_fd = 1'b0;
  logic [15:0] m_lc = '0, m_rc = '0;
  bit          m_started = 0, m_push = 0;

  function automatic bit far_out(input seg_t s);
    return (s.sx >= 320 && s.ex >= 320) || (s.sx < -320 && s.ex < -320) ||
           (s.sy >= 240 && s.ey >= 240) || (s.sy < -240 && s.ey < -240);
  endfunction

  always @(posedge clk) begin
    m_started = 1;
    if (rst) begin
      m_q.delete(); m_cur = '0; m_stage = M_IDLE;
      m_buf = 0; m_fd = 0; m_lc = '0; m_rc = '0;
    end else begin
      m_push = in_valid && (m_q.size() < DEPTH);
      m_in = mk(in_start_x, in_start_y, in_end_x, in_end_y, in_color, in_last);
      m_fd = 0;
      case (m_stage)
        M_IDLE: if (m_q.size() > 0) begin
          m_h = m_q.pop_front();
`ifdef VECTOR_TRIVIAL_REJECT_EN
          if (far_out(m_h)) begin
            if (m_rc != 16'hFFFF) m_rc++;
            if (m_h.last) m_stage = M_VB;
          end else
`endif
          begin
            m_cur = m_h; m_stage = M_OFFER;
          end
        end
        M_OFFER: if (rast_ready) begin
          if (m_lc != 16'hFFFF) m_lc++;
          m_stage = M_DRAW;
        end
        M_DRAW: if (rast_done) m_stage = m_cur.last ? M_VB : M_IDLE;
        default: if (vblank) begin
          m_buf = ~m_buf; m_fd = 1; m_lc = '0; m_rc = '0; m_stage = M_IDLE;
        end
      endcase
      if (m_push) m_q.push_back(m_in);
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("in_ready",   in_ready, m_q.size() < DEPTH);
      chk("rast_go",    rast_go, (m_stage == M_OFFER) && rast_ready);
      chk("rast_sx",    rast_start_x, m_cur.sx);
      chk("rast_sy",    rast_start_y, m_cur.sy);
      chk("rast_ex",    rast_end_x, m_cur.ex);
      chk("rast_ey",    rast_end_y, m_cur.ey);
      chk("rast_color", rast_color, m_cur.color);
      chk("buf_sel",    buf_sel, m_buf);
      chk("frame_done", frame_done, m_fd);
      chk("line_count", line_count, m_lc);
      chk("busy",       busy, (m_stage != M_IDLE) || (m_q.size() > 0));
`ifdef VECTOR_TRIVIAL_REJECT_EN
      chk("reject_count", reject_count, m_rc);
`endif
    end
  end

  // ---------------- directed and random scenarios ----------------
  task automatic wait_go(input int base, input int n, input int budget, input string name);
    for (int i = 0; i < budget && go_cnt - base < n; i++) @(negedge clk);
    chk(name, go_cnt - base, n);
  endtask

  task automatic wait_stage(input int st, input int budget, input string name);
    for (int i = 0; i < budget && m_stage != st; i++) @(negedge clk);
    chk(name, m_stage, st);
  endtask

  task automatic wait_frame(input int base, input int budget, input string name);
    for (int i = 0; i < budget && fd_cnt == base; i++) @(negedge clk);
    chk(name, fd_cnt - base, 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget && !(src_q.size() == 0 && m_q.size() == 0 && m_stage == M_IDLE); i++)
      @(negedge clk);
    chk(name, (src_q.size() == 0 && m_q.size() == 0 && m_stage == M_IDLE), 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, g0, g1, f0;
    rst = 1; in_valid = 0; rast_ready = 0; rast_done = 0; vblank = 0;
    in_start_x = '0; in_start_y = '0; in_end_x = '0; in_end_y = '0; in_color = '0; in_last = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_line_count", line_count, 0);
    chk("reset_buf_sel", buf_sel, 0);

    // Single line, exact latency and flip on vblank
    g0 = go_cnt;
    src_q.push_back(mk(-25, 50, 75, 250, 7, 1));
    wait_go(g0, 1, 20, "single_go");
    chk("single_latency", last_go_cyc - last_acc_cyc, 2);
    chk("single_sx", go_seg.sx, -25);
    chk("single_sy", go_seg.sy, 50);
    chk("single_ex", go_seg.ex, 75);
    chk("single_ey", go_seg.ey, 250);
    chk("single_color", go_seg.color, 7);
    wait_stage(M_VB, 50, "single_reach_flip");
    repeat (5) @(negedge clk);
    chk("single_buf_before", buf_sel, 0);
    chk("single_lc_before", line_count, 1);
    f0 = fd_cnt;
    vb_pct = 100; vb_block = 0;
    wait_frame(f0, 10, "single_frame_done");
    chk("single_buf_after", buf_sel, 1);
    chk("single_lc_after", line_count, 0);
    repeat (3) @(negedge clk);
    chk("single_one_pulse", fd_cnt - f0, 1);

    // Backpressure: fill with rasterizer stalled, then drain a 40-segment stream
    vb_block = 1; rr_en = 0; a0 = acc_cnt; g0 = go_cnt;
    for (int i = 0; i < 40; i++) src_q.push_back(rnd_seg(200, i == 39));
    repeat (40) @(negedge clk);
    chk("bp_accepted", acc_cnt - a0, DEPTH + 1);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_no_go", go_cnt - g0, 0);
    rr_en = 1; vb_block = 0; vb_pct = 25;
    wait_go(g0, 40, 3000, "bp_all_launched");
    wait_idle(500, "bp_idle");

    // Reset while a line is being drawn; the late rast_done must be ignored
    vb_block = 1; done_hold = 1; g0 = go_cnt;
    src_q.push_back(mk(10, 20, 30, 40, 3, 1));
    wait_go(g0, 1, 20, "rst_go");
    repeat (2) @(negedge clk);
    chk("rst_lc_before", line_count, 1);
    f0 = fd_cnt;
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_sx_cleared", rast_start_x, 0);
    chk("rst_lc_cleared", line_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_buf_sel", buf_sel, 0);
    @(negedge clk);
    rcnt = 0; done_hold = 0;
    repeat (6) @(negedge clk);
    chk("rst_no_flip", fd_cnt - f0, 0);
    chk("rst_no_extra_go", go_cnt - g0, 1);
    chk("rst_lc_after", line_count, 0);

    // Flip blocks launches of the next frame until vblank
    a0 = acc_cnt;
    src_q.push_back(mk(-100, -100, 100, 100, 5, 1));
    wait_stage(M_VB, 100, "flip_reach");
    g1 = go_cnt;
    for (int i = 0; i < 3; i++) src_q.push_back(rnd_seg(200, i == 2));
    repeat (100) @(negedge clk);
    chk("flip_blocked_no_go", go_cnt - g1, 0);
    chk("flip_queued", acc_cnt - a0, 4);
    chk("flip_buf_pending", buf_sel, 0);
    f0 = fd_cnt;
    vb_pct = 100; vb_block = 0;
    wait_frame(f0, 10, "flip_done");
    chk("flip_buf_after", buf_sel, 1);
    wait_go(g1, 3, 200, "flip_resume");
    wait_idle(200, "flip_idle");

    // Random stream
    valid_pct = 70; ready_pct = 60; vb_pct = 10;
    for (int i = 0; i < 300; i++) src_q.push_back(rnd_seg(700, i == 299 || $urandom_range(0, 6) == 0));
    wait_idle(30000, "random_idle");
`ifndef VECTOR_TRIVIAL_REJECT_EN
    chk("random_all_launched", go_cnt, acc_cnt);
`endif

`ifdef VECTOR_TRIVIAL_REJECT_EN
    vb_block = 1; g0 = go_cnt; valid_pct = 100;
    src_q.push_back(mk(400, 0, 500, 10, 2, 0));
    src_q.push_back(mk(0, 0, 10, 10, 9, 1));
    wait_stage(M_VB, 100, "rej_reach_flip");
    chk("rej_one_go", go_cnt - g0, 1);
    chk("rej_count", reject_count, 1);
    chk("rej_lc", line_count, 1);
    f0 = fd_cnt;
    vb_block = 0; vb_pct = 100;
    wait_frame(f0, 10, "rej_flip");
    chk("rej_count_cleared", reject_count, 0);
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
